// File: rtl/miner_core_ctrl.sv
// Sequencer for one SHA-256 miner core: LOAD -> ROUNDS rounds -> FINAL -> CHECK per nonce.
// Latency: first load_init 1 cycle after start; 1+ROUNDS+1+1 cycles per nonce.
// Backpressure: none; abort is deferred to the next nonce boundary, status held until ack.
module miner_core_ctrl #(
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 7
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ack,
  input  logic [31:0]      nonce_init,
  input  logic [31:0]      nonce_last,
  input  logic             hash_lt_target,
  input  logic [CNT_W-1:0] count,
  input  logic             rollover_flag,
  output logic             enable_timer,
  output logic [CNT_W-1:0] rollover_val,
  output logic             load_init,
  output logic             round_en,
  output logic             final_add,
  output logic [31:0]      nonce,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [31:0]      golden_nonce
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_FINAL,
    S_CHECK,
    S_FOUND,
    S_EXHAUST
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_nonce;
  logic [31:0] r_last;
  logic [31:0] r_golden;
  logic        r_abort_pend;
  logic        w_abort_any;
  logic        w_unused;

  // The round index is consumed by the datapath directly; only the wrap flag matters here.
  assign w_unused     = ^count;
  assign rollover_val = CNT_W'(ROUNDS - 1);
  assign nonce        = r_nonce;
  assign golden_nonce = r_golden;
  // An abort arriving in the CHECK cycle itself must still stop the run.
  assign w_abort_any  = r_abort_pend | abort;

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    w_next       = r_state;
    enable_timer = 1'b0;
    load_init    = 1'b0;
    round_en     = 1'b0;
    final_add    = 1'b0;
    busy         = 1'b0;
    found        = 1'b0;
    exhausted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        load_init = 1'b1;
        busy      = 1'b1;
        w_next    = S_ROUND;
      end
      S_ROUND: begin
        enable_timer = 1'b1;
        round_en     = 1'b1;
        busy         = 1'b1;
        if (rollover_flag) w_next = S_FINAL;
      end
      S_FINAL: begin
        final_add = 1'b1;
        busy      = 1'b1;
        w_next    = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
        if (hash_lt_target)         w_next = S_FOUND;
        else if (r_nonce == r_last) w_next = S_EXHAUST;
        else if (w_abort_any)       w_next = S_IDLE;
        else                        w_next = S_LOAD;
      end
      S_FOUND: begin
        found = 1'b1;
        if (ack) w_next = S_IDLE;
      end
      S_EXHAUST: begin
        exhausted = 1'b1;
        if (ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Nonce range bookkeeping and golden nonce capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_nonce  <= '0;
      r_last   <= '0;
      r_golden <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_nonce <= nonce_init;
        r_last  <= nonce_last;
      end else if (r_state == S_CHECK && w_next == S_LOAD) begin
        r_nonce <= r_nonce + 32'd1;
      end
      if (r_state == S_CHECK && w_next == S_FOUND) r_golden <= r_nonce;
    end
  end

  // Pending abort: latched while busy, dropped whenever the FSM enters IDLE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_abort_pend <= 1'b0;
    end else if (w_next == S_IDLE && r_state != S_IDLE) begin
      r_abort_pend <= 1'b0;
    end else if (busy && abort) begin
      r_abort_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_miner_core_ctrl.sv
// Bench for miner_core_ctrl: timer model, randomized runs, scoreboard-checked events.
// Latency: expected event cycles come from the 1+ROUNDS+1+1 per-nonce arithmetic.
// Backpressure: none; random start/ack noise is injected while the core is busy.
`timescale 1ns/1ps
module tb_miner_core_ctrl;
  localparam int ROUNDS = 64;
  localparam int CNT_W  = 7;
  localparam int PER    = ROUNDS + 3;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             ack = 1'b0;
  logic [31:0]      nonce_init = '0;
  logic [31:0]      nonce_last = '0;
  logic             hash_lt_target = 1'b0;
  logic [CNT_W-1:0] count;
  logic             rollover_flag;
  logic             enable_timer;
  logic [CNT_W-1:0] rollover_val;
  logic             load_init;
  logic             round_en;
  logic             final_add;
  logic [31:0]      nonce;
  logic             busy;
  logic             found;
  logic             exhausted;
  logic [31:0]      golden_nonce;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  logic [31:0] g_exp = '0;

  typedef struct {
    int          kind;  // 0: load_init event, 1: end of run (busy falls)
    int unsigned cyc;
    logic [31:0] nonce;
    logic        f;
    logic        e;
    logic [31:0] g;
  } ev_t;
  ev_t sb[$];

  miner_core_ctrl #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .abort(abort), .ack(ack),
    .nonce_init(nonce_init), .nonce_last(nonce_last), .hash_lt_target(hash_lt_target),
    .count(count), .rollover_flag(rollover_flag), .enable_timer(enable_timer),
    .rollover_val(rollover_val), .load_init(load_init), .round_en(round_en),
    .final_add(final_add), .nonce(nonce), .busy(busy), .found(found),
    .exhausted(exhausted), .golden_nonce(golden_nonce)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Round timer: counts while enabled, wraps after rollover_val, cleared by reset.
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) count <= '0;
    else if (enable_timer) count <= (count == rollover_val) ? '0 : count + 1'b1;
  end
  assign rollover_flag = (count == rollover_val);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: per-round index, round count per hash, and scoreboard events.
  int   rnd = 0;
  logic busy_d = 1'b0;
  always @(negedge clk) begin
    ev_t ev;
    if (!n_rst) begin
      busy_d = 1'b0;
      rnd    = 0;
    end else begin
      if (round_en) begin
        chk("round_index", 64'(count), 64'(rnd));
        rnd++;
      end
      if (final_add) begin
        chk("rounds_per_hash", 64'(rnd), 64'(ROUNDS));
        rnd = 0;
      end
      if (load_init) begin
        rnd = 0;
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_load: nonce %0h with no expected event (cycle %0d)", nonce, cyc);
        end else begin
          ev = sb.pop_front();
          chk("load_kind", 64'(ev.kind), 64'd0);
          chk("load_nonce", 64'(nonce), 64'(ev.nonce));
          chk("load_cycle", 64'(cyc), 64'(ev.cyc));
        end
      end
      if (busy_d && !busy) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: busy fell with no expected event (cycle %0d)", cyc);
        end else begin
          ev = sb.pop_front();
          chk("done_kind", 64'(ev.kind), 64'd1);
          chk("done_cycle", 64'(cyc), 64'(ev.cyc));
          chk("done_found", 64'(found), 64'(ev.f));
          chk("done_exhausted", 64'(exhausted), 64'(ev.e));
          chk("done_nonce", 64'(nonce), 64'(ev.nonce));
          chk("done_golden", 64'(golden_nonce), 64'(ev.g));
        end
      end
      busy_d = busy;
    end
  end

  // One run: model outcome from range/hit/abort, push events, drive stimulus, ack status.
  // hit: CHECK index (0-based) where hash_lt_target=1, -1 none. abort_off: cycles after start, <=0 none.
  task automatic run(input logic [31:0] init, input logic [31:0] last, input int hit, input int abort_off);
    logic [31:0] span32;
    int          k, aj, res, chkn;
    int unsigned tstart, tdone;
    logic        fa_prev;
    ev_t         ev;
    @(negedge clk);
    start = 1'b1; nonce_init = init; nonce_last = last; tstart = cyc;
    span32 = last - init;
    k   = int'(span32);
    res = 2;
    if (hit >= 0 && hit <= k) begin k = hit; res = 1; end
    aj = (abort_off > 0) ? (abort_off - 1) / PER : -1;
    if (aj >= 0 && aj < k) begin k = aj; res = 0; end
    for (int i = 0; i <= k; i++) begin
      ev.kind = 0; ev.cyc = tstart + 1 + PER * i; ev.nonce = init + 32'(i);
      ev.f = 1'b0; ev.e = 1'b0; ev.g = '0;
      sb.push_back(ev);
    end
    if (res == 1) g_exp = init + 32'(k);
    tdone = tstart + PER * (k + 1) + 1;
    ev.kind = 1; ev.cyc = tdone; ev.nonce = init + 32'(k);
    ev.f = (res == 1); ev.e = (res == 2); ev.g = g_exp;
    sb.push_back(ev);
    fa_prev = 1'b0; chkn = 0;
    while (cyc < tdone) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0; ack = 1'b0;
      if (fa_prev) begin
        hash_lt_target = (chkn == hit);
        chkn++;
      end else begin
        hash_lt_target = 1'($urandom);
      end
      fa_prev = final_add;
      if (abort_off > 0 && cyc == tstart + abort_off) abort = 1'b1;
      if (cyc > tstart && cyc < tdone) begin
        start = ($urandom_range(0, 7) == 0);
        ack   = ($urandom_range(0, 7) == 0);
        nonce_init = $urandom; nonce_last = $urandom;
      end
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; ack = 1'b0; hash_lt_target = 1'b0;
    chk("events_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    if (res != 0) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk("found_held", 64'(found), 64'(res == 1));
      chk("exhausted_held", 64'(exhausted), 64'(res == 2));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      chk("ack_found", 64'(found), 64'd0);
      chk("ack_exhausted", 64'(exhausted), 64'd0);
      chk("ack_busy", 64'(busy), 64'd0);
      chk("ack_golden", 64'(golden_nonce), 64'(g_exp));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_enable_timer"}, 64'(enable_timer), 64'd0);
    chk({tag, "_rollover_val"}, 64'(rollover_val), 64'(ROUNDS - 1));
    chk({tag, "_load_init"}, 64'(load_init), 64'd0);
    chk({tag, "_round_en"}, 64'(round_en), 64'd0);
    chk({tag, "_final_add"}, 64'(final_add), 64'd0);
    chk({tag, "_nonce"}, 64'(nonce), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_found"}, 64'(found), 64'd0);
    chk({tag, "_exhausted"}, 64'(exhausted), 64'd0);
    chk({tag, "_golden"}, 64'(golden_nonce), 64'd0);
  endtask

  initial begin
    int unsigned ts;
    logic [31:0] ri;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    #1 check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    // Abort and ack in IDLE must leave nothing behind.
    @(negedge clk); abort = 1'b1; ack = 1'b1;
    @(negedge clk); abort = 1'b0; ack = 1'b0;
    chk("idle_ignores_abort_busy", 64'(busy), 64'd0);
    run(32'd5, 32'd7, -1, -1);
    run(32'h10, 32'h20, 2, -1);
    run(32'd9, 32'd100, -1, 30);
    run(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    run(32'hFFFF_FFFE, 32'd1, -1, -1);
    run(32'd3, 32'd5, 2, -1);
    run(32'd20, 32'd30, -1, 2 * PER);
    run(32'd40, 32'd50, -1, 2 * PER + 1);
    // Reset in the middle of round 30 of the first hash.
    @(negedge clk);
    start = 1'b1; nonce_init = 32'h40; nonce_last = 32'h50; ts = cyc;
    sb.push_back('{kind: 0, cyc: ts + 1, nonce: 32'h40, f: 1'b0, e: 1'b0, g: '0});
    @(negedge clk); start = 1'b0;
    while (cyc < ts + 2 + 30) @(negedge clk);
    @(posedge clk);
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("midrun_reset");
    g_exp = '0;
    @(negedge clk); @(negedge clk);
    n_rst = 1'b1;
    chk("midrun_events_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    run(32'h40, 32'h41, -1, -1);
    // Randomized runs.
    for (int r = 0; r < 5; r++) begin
      int span, hit, aoff;
      ri   = $urandom;
      span = $urandom_range(0, 2);
      hit  = int'($urandom_range(0, 3)) - 1;
      aoff = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, PER * (span + 1))) : -1;
      run(ri, ri + 32'(span), hit, aoff);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
